mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the byte-addressable data RAM in the MIPS datapath.
- Accepts word, halfword and byte loads and stores from the core.
- Loads: extracts and sign- or zero-extends the addressed lane.
- Stores: because the RAM only performs full 32-bit little-endian writes, sub-word stores are done as read-modify-write sequences.
- Presents a simple req/busy/done handshake to the core and a word-aligned port to the RAM.

Parameters:
- addr_width, 32, width of byte address on both sides.
- data_width, 8, RAM byte width; the word is 4*data_width = 32 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  access request; sampled only in IDLE.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_size  input  2  00 byte, 01 halfword, 10/11 word.
- cpu_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- cpu_addr  input  addr_width  byte address.
- cpu_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- cpu_rdata  output  32  extended load result; registered.
- cpu_busy  output  1  high whenever state != IDLE.
- cpu_done  output  1  one-cycle completion pulse.
- cpu_misalign  output  1  alignment fault flag, valid with cpu_done (see Optional Feature).
- mem_we  output  1  RAM write enable.
- mem_addr  output  addr_width  word-aligned RAM address, bits [1:0] = 00.
- mem_wdata  output  32  RAM write word, little-endian.
- mem_rdata  input  32  RAM combinational read word.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs = 0, including cpu_rdata, mem_addr and mem_wdata. mem_we drops immediately, even if reset arrives mid-sequence. An interrupted RMW leaves RAM unmodified if reset hits before the WRITE edge.
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - On cpu_req, latch we, size, unsigned, wdata, lane = addr[1:0].
  - mem_addr <= {cpu_addr[addr_width-1:2], 2'b00}.
  - Next state ACCESS.
- ACCESS, load:
  - Select lane from mem_rdata: byte lane k = bits [8k+7:8k]; half uses lane[1] (0 = [15:0], 1 = [31:16]).
  - Extend per cpu_unsigned; cpu_rdata <= result. Word loads pass through unchanged.
  - Next state DONE.
- ACCESS, word store: mem_we = 1, mem_wdata = latched wdata. Next state DONE.
- ACCESS, sub-word store: capture mem_rdata into old_word. mem_we = 0. Next state WRITE.
- WRITE:
  - mem_we = 1, mem_wdata = old_word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next state DONE.
- DONE: cpu_done = 1 for exactly one cycle. Next state IDLE.
- mem_we is asserted only in ACCESS (word store) or WRITE, and for exactly one cycle per store.
- Latency from the req edge (cycle 0): load done at cycle 2; word store done at 2; byte/half store done at 3.
- cpu_req is ignored while busy, including in DONE; the core must hold off until cpu_busy = 0.
- cpu_rdata holds its value until the next completed load. Stores do not modify it.
- Alignment without the feature: low address bits below access size are ignored. Half forces addr[0] = 0; word forces addr[1:0] = 00.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a request with half and addr[0] = 1, or word and addr[1:0] != 00, goes IDLE -> DONE. No RAM read or write occurs, cpu_misalign = 1 with cpu_done, and cpu_rdata is unchanged. Total latency is 1 cycle.
- Undefined: cpu_misalign is tied 0 and low address bits are masked as in Behaviour.

Test Plan:
- RAM word @0x10 = 0x8899AABB. lb 0x11 -> cpu_rdata 0xFFFFFFAA at cycle 2; lbu 0x11 -> 0x000000AA.
- lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899; lw 0x10 -> 0x8899AABB, no mem_we at any point.
- sb 0x12 wdata 0x12345655 -> mem_we high only in cycle 2, mem_wdata 0x8855AABB, done at cycle 3. sh 0x10 wdata 0x0000CAFE -> word becomes 0x8855CAFE.
- sw 0x20 0xDEADBEEF -> mem_we one cycle at cycle 1, mem_addr 0x20, done at cycle 2. Readback lw 0x20 = 0xDEADBEEF.
- Assert reset during WRITE of sb 0x10 -> mem_we = 0 immediately, cpu_busy = 0, @0x10 unchanged. A cpu_req pulsed while busy is ignored.
- MISALIGN_TRAP_EN defined: lh 0x13 -> done at cycle 1, cpu_misalign = 1, no RAM access. Undefined: same access reads lane at 0x12.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end: lane extract/extend for loads, RMW for sub-word stores.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking.
module mem_access_unit #(
  parameter int addr_width = 32,
  parameter int data_width = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [1:0]                cpu_size,
  input  logic                      cpu_unsigned,
  input  logic [addr_width-1:0]     cpu_addr,
  input  logic [4*data_width-1:0]   cpu_wdata,
  output logic [4*data_width-1:0]   cpu_rdata,
  output logic                      cpu_busy,
  output logic                      cpu_done,
  output logic                      cpu_misalign,
  output logic                      mem_we,
  output logic [addr_width-1:0]     mem_addr,
  output logic [4*data_width-1:0]   mem_wdata,
  input  logic [4*data_width-1:0]   mem_rdata
);

  localparam int B = data_width;
  localparam int H = 2 * data_width;
  localparam int W = 4 * data_width;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic [W-1:0]          wdata_q;
  logic [W-1:0]          rdata_q;
  logic                  done_q;
  logic                  mis_q;
  logic                  mem_we_q;
  logic [addr_width-1:0] mem_addr_q;
  logic [W-1:0]          mem_wdata_q;
  logic                  trap;

`ifdef MISALIGN_TRAP_EN
  assign trap = cpu_size[1] ? (|cpu_addr[1:0])
                            : (cpu_size[0] & cpu_addr[0]);
`else
  assign trap = 1'b0;
`endif

  function automatic logic [W-1:0] load_ext(
    input logic [W-1:0] w,
    input logic [1:0]   sz,
    input logic [1:0]   ln,
    input logic         uns
  );
    logic [B-1:0] b;
    logic [H-1:0] h;
    b = w[ln*B +: B];
    h = ln[1] ? w[W-1:H] : w[H-1:0];
    unique case (1'b1)
      sz[1]:   load_ext = w;
      sz[0]:   load_ext = {{(W-H){~uns & h[H-1]}}, h};
      default: load_ext = {{(W-B){~uns & b[B-1]}}, b};
    endcase
  endfunction

  // Splice the store lane(s) into the word read back from RAM.
  function automatic logic [W-1:0] merge(
    input logic [W-1:0] w,
    input logic [W-1:0] wd,
    input logic         half,
    input logic [1:0]   ln
  );
    merge = w;
    if (half) merge[ln[1]*H +: H] = wd[H-1:0];
    else      merge[ln*B +: B]    = wd[B-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            size_q  <= cpu_size;
            uns_q   <= cpu_unsigned;
            lane_q  <= cpu_addr[1:0];
            wdata_q <= cpu_wdata;
            if (trap) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              mem_addr_q <= {cpu_addr[addr_width-1:2], 2'b00};
              if (cpu_we && cpu_size[1]) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= cpu_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_ext(mem_rdata, size_q, lane_q, uns_q);
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (size_q[1]) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge(mem_rdata, wdata_q, size_q[0], lane_q);
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata    = rdata_q;
  assign cpu_busy     = (state_q != IDLE);
  assign cpu_done     = done_q;
  assign cpu_misalign = mis_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small word RAM model.
// Expected results are queued per request and compared on completion.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_misalign;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    int          wes;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] ram [0:63];
  logic [5:0]  ridx;

  always #5 clk = ~clk;

  assign ridx      = mem_addr[7:2];
  assign mem_rdata = ram[ridx];

  always @(posedge clk) begin
    if (mem_we) ram[ridx] <= mem_wdata;
  end

  mem_access_unit #(.addr_width(32), .data_width(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_misalign (cpu_misalign),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Drives one request from a negedge in IDLE and observes it to completion.
  task automatic run_op(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  bit          poke,
    output int          lat,
    output int          wes,
    output int          wec,
    output logic [31:0] wa,
    output logic [31:0] wdo,
    output logic [31:0] rd,
    output logic        mis,
    output logic        busy_after
  );
    lat = 0; wes = 0; wec = 0; wa = '0; wdo = '0; rd = '0; mis = 1'b0;
    cpu_req      = 1'b1;
    cpu_we       = we;
    cpu_size     = sz;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wd;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        wec = c;
        wa  = mem_addr;
        wdo = mem_wdata;
      end
      if (cpu_done) begin
        lat = c;
        rd  = cpu_rdata;
        mis = cpu_misalign;
        break;
      end
      if (poke) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = 2'b10;
        cpu_addr  = 32'h30;
        cpu_wdata = 32'hBAD0BAD0;
      end
    end
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    busy_after = cpu_busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want %h", cpu_rdata, 32'h0);
    end
    n_checks++;
    if ({cpu_busy, cpu_done, cpu_misalign, mem_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {cpu_busy, cpu_done, cpu_misalign, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h %h want 0 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic [1:0]  sz  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    logic        un  [7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [31:0] ad  [7] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10,
                             32'h10, 32'h13};
    logic [31:0] ex  [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                             32'h00008899, 32'h8899AABB, 32'h000000BB,
                             32'hFFFFFF88};
    int lat, wes, wec;
    logic [31:0] wa, wdo, rd;
    logic mis, ba;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{lat: 2, rdata: ex[i], mis: 1'b0, wes: 0});
      run_op(1'b0, sz[i], un[i], ad[i], 32'h0, 1'b0,
             lat, wes, wec, wa, wdo, rd, mis, ba);
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e.rdata) begin
        n_fail++;
        $display("FAIL load_rdata[%0d]: got %h want %h", i, rd, e.rdata);
      end
      n_checks++;
      if (lat !== e.lat || wes !== e.wes || mis !== e.mis) begin
        n_fail++;
        $display("FAIL load_timing[%0d]: got lat %0d we %0d mis %b want %0d %0d %b",
                 i, lat, wes, mis, e.lat, e.wes, e.mis);
      end
    end
  endtask

  task automatic test_stores;
    int lat, wes, wec;
    logic [31:0] wa, wdo, rd;
    logic mis, ba;
    run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h12345655, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    n_checks++;
    if (lat !== 3 || wes !== 1 || wec !== 2) begin
      n_fail++;
      $display("FAIL sb_timing: got lat %0d we %0d@%0d want 3 1@2", lat, wes, wec);
    end
    n_checks++;
    if (wdo !== 32'h8855AABB || wa !== 32'h10) begin
      n_fail++;
      $display("FAIL sb_write: got %h @%h want 8855aabb @10", wdo, wa);
    end
    n_checks++;
    if (rd !== 32'hFFFFFF88) begin
      n_fail++;
      $display("FAIL sb_keeps_rdata: got %h want ffffff88", rd);
    end
    run_op(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000CAFE, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    n_checks++;
    if (lat !== 3 || wes !== 1 || wec !== 2 || ram[4] !== 32'h8855CAFE) begin
      n_fail++;
      $display("FAIL sh: got lat %0d we %0d@%0d ram %h want 3 1@2 8855cafe",
               lat, wes, wec, ram[4]);
    end
    run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    n_checks++;
    if (lat !== 2 || wes !== 1 || wec !== 1 || wa !== 32'h20) begin
      n_fail++;
      $display("FAIL sw_timing: got lat %0d we %0d@%0d addr %h want 2 1@1 20",
               lat, wes, wec, wa);
    end
    exp_q.push_back('{lat: 2, rdata: 32'hDEADBEEF, mis: 1'b0, wes: 0});
    run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    n_checks++;
    if (rd !== exp_q[0].rdata || lat !== exp_q[0].lat) begin
      n_fail++;
      $display("FAIL sw_readback: got %h lat %0d want %h lat %0d",
               rd, lat, exp_q[0].rdata, exp_q[0].lat);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_busy_ignore;
    int lat, wes, wec;
    logic [31:0] wa, wdo, rd;
    logic mis, ba;
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    n_checks++;
    if (rd !== 32'h8855CAFE || lat !== 2) begin
      n_fail++;
      $display("FAIL busy_load: got %h lat %0d want 8855cafe lat 2", rd, lat);
    end
    n_checks++;
    if (ba !== 1'b0 || wes !== 0 || ram[12] !== 32'h11111111) begin
      n_fail++;
      $display("FAIL busy_ignore: got busy %b we %0d ram %h want 0 0 11111111",
               ba, wes, ram[12]);
    end
  endtask

  task automatic test_reset_mid;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_size  = 2'b00;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h77;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_write_phase: got mem_we %b want 1", mem_we);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got we %b busy %b rdata %h want 0 0 0",
               mem_we, cpu_busy, cpu_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram[4] !== 32'h8855CAFE) begin
      n_fail++;
      $display("FAIL reset_mid_ram: got %h want 8855cafe", ram[4]);
    end
  endtask

  task automatic test_misalign;
    int lat, wes, wec;
    logic [31:0] wa, wdo, rd;
    logic mis, ba;
    exp_t e;
    run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
`ifdef MISALIGN_TRAP_EN
    exp_q.push_back('{lat: 1, rdata: 32'hDEADBEEF, mis: 1'b1, wes: 0});
    exp_q.push_back('{lat: 1, rdata: 32'hDEADBEEF, mis: 1'b1, wes: 0});
`else
    exp_q.push_back('{lat: 2, rdata: 32'hFFFF8855, mis: 1'b0, wes: 0});
    exp_q.push_back('{lat: 2, rdata: 32'hDEADBEEF, mis: 1'b0, wes: 0});
`endif
    run_op(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.rdata || lat !== e.lat || mis !== e.mis || wes !== e.wes) begin
      n_fail++;
      $display("FAIL lh_13: got %h lat %0d mis %b want %h lat %0d mis %b",
               rd, lat, mis, e.rdata, e.lat, e.mis);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h23, 32'h0, 1'b0,
           lat, wes, wec, wa, wdo, rd, mis, ba);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.rdata || lat !== e.lat || mis !== e.mis) begin
      n_fail++;
      $display("FAIL lw_23: got %h lat %0d mis %b want %h lat %0d mis %b",
               rd, lat, mis, e.rdata, e.lat, e.mis);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4]  = 32'h8899AABB;
    ram[12] = 32'h11111111;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_size     = 2'b00;
    cpu_unsigned = 1'b0;
    cpu_addr     = 32'h0;
    cpu_wdata    = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_busy_ignore();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
